// File: rtl/huffman_pkg.sv
// Shared types and constants for the unary-prefix Huffman encoder.
package huffman_pkg;

  localparam int unsigned SYM_W_DEF    = 4;
  localparam int unsigned MAX_CODE_LEN = 1 << SYM_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ZEROS,
    ST_ONE
  } huff_state_e;

endpackage

// File: rtl/huffman_sym_fifo.sv
// Synchronous symbol FIFO; pointers wrap modulo DEPTH (power of 2), full blocks push.
module huffman_sym_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  // Push is gated by full alone, so a simultaneous pop cannot free a slot early.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/huffman_encoder.sv
// Serial encoder: symbol k -> k zeros then a one, one bit per unstalled clock.
// Optional counters sym_count/bit_count are enabled by defining HUFF_ENC_STATS_EN.
module huffman_encoder
  import huffman_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYM_W      = SYM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             out_stall,
  output logic             out,
  output logic             out_valid,
  output logic             busy
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0]      sym_count,
  output logic [31:0]      bit_count
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [SYM_W-1:0] fifo_dout, sym_m1;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]  fifo_count;

  huff_state_e      state_q, state_d;
  logic [SYM_W-1:0] rem_q, rem_d;
  logic             out_q, out_d, out_valid_q, out_valid_d;

  huffman_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sym_valid),
    .pop   (fifo_pop),
    .din   (sym_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sym_ready = !fifo_full;
  assign sym_m1    = fifo_dout - 1'b1;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    fifo_pop    = 1'b0;
    if (!out_stall) begin
      out_valid_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (fifo_empty) begin
            out_valid_d = 1'b0;
          end else begin
            fifo_pop = 1'b1;
            if (fifo_dout == '0) begin
              out_d = 1'b1;
            end else begin
              out_d   = 1'b0;
              rem_d   = sym_m1;
              state_d = (sym_m1 != '0) ? ST_ZEROS : ST_ONE;
            end
          end
        end
        ST_ZEROS: begin
          out_d = 1'b0;
          rem_d = rem_q - 1'b1;
          if (rem_q == SYM_W'(1)) state_d = ST_ONE;
        end
        ST_ONE: begin
          // Return to idle so the next symbol pops on the following edge with no gap.
          out_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (fifo_count != '0) || (state_q != ST_IDLE) || !fifo_empty;

`ifdef HUFF_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= '0;
      bit_count <= '0;
    end else begin
      if (fifo_pop)    sym_count <= sym_count + 16'd1;
      if (out_valid_d) bit_count <= bit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: vector table, corner sequences, random loopback.
module tb_huffman_encoder;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SYM_W      = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [SYM_W-1:0] sym_in = '0;
  logic             sym_valid = 1'b0;
  logic             out_stall = 1'b0;
  logic             sym_ready, out, out_valid, busy;

  huffman_encoder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYM_W      (SYM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .out_stall (out_stall),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sym;
    logic [15:0] code;
    int          len;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_v = -1;
  int   last_v = -1;
  bit   cap[$];
  int   model_q[$];
  int   dec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: record accepted pushes into the model, sample outputs 1 ns after the edge.
  task automatic step();
    bit acc;
    acc = sym_valid && sym_ready;
    @(posedge clk);
    if (acc) model_q.push_back(int'(sym_in));
    #1;
    cyc++;
    if (out_valid) begin
      cap.push_back(out);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic clear_cap();
    cap.delete();
    model_q.delete();
    first_v = -1;
    last_v  = -1;
  endtask

  task automatic push_sym(input logic [3:0] s);
    sym_in    = s;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (!busy && !out_valid) break;
      step();
    end
    check(name, {30'd0, busy, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pack_cap();
    logic [31:0] v;
    v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  // Reference bitstream for the queued symbols: s zeros then a one, per symbol.
  function automatic logic [31:0] model_bits(output int len);
    logic [31:0] v;
    v   = '0;
    len = 0;
    foreach (model_q[i]) begin
      v   = (v << (model_q[i] + 1)) | 32'd1;
      len = len + model_q[i] + 1;
    end
    return v;
  endfunction

  initial begin
    int          push_cyc, exp_len, z, n;
    logic [31:0] exp_bits;

    vecs[0] = '{sym: 4'd0,  code: 16'h0001, len: 1};
    vecs[1] = '{sym: 4'd3,  code: 16'h0001, len: 4};
    vecs[2] = '{sym: 4'd15, code: 16'h0001, len: 16};
    vecs[3] = '{sym: 4'd1,  code: 16'h0001, len: 2};
    vecs[4] = '{sym: 4'd8,  code: 16'h0001, len: 9};
    vecs[5] = '{sym: 4'd14, code: 16'h0001, len: 15};

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_sym_ready", {31'd0, sym_ready}, 32'd1);

    // Single-symbol codewords with first-bit latency
    foreach (vecs[k]) begin
      clear_cap();
      push_sym(vecs[k].sym);
      push_cyc = cyc;
      drain(40, $sformatf("vec%0d_idle", k));
      check($sformatf("vec%0d_len", k), cap.size(), vecs[k].len);
      check($sformatf("vec%0d_code", k), pack_cap(), {16'd0, vecs[k].code});
      check($sformatf("vec%0d_latency", k), first_v - push_cyc, 1);
    end

    // Symbol 0: one valid bit, busy already low on that cycle, then idle
    clear_cap();
    push_sym(4'd0);
    step();
    check("sym0_bit", {30'd0, out_valid, out}, 32'd3);
    check("sym0_busy", {31'd0, busy}, 32'd0);
    step();
    check("sym0_after", {31'd0, out_valid}, 32'd0);

    // Back-to-back 2,0,1 -> 001101 contiguous
    clear_cap();
    push_sym(4'd2);
    push_sym(4'd0);
    push_sym(4'd1);
    drain(40, "b2b_idle");
    check("b2b_bits", pack_cap(), 32'b001101);
    check("b2b_len", cap.size(), 6);
    check("b2b_span", last_v - first_v + 1, 6);

    // Stall mid-codeword on symbol 5
    clear_cap();
    push_sym(4'd5);
    step();
    step();
    check("stall_pre", cap.size(), 2);
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_ov%0d", i), {31'd0, out_valid}, 32'd0);
    end
    out_stall = 1'b0;
    drain(40, "stall_idle");
    check("stall_bits", pack_cap(), 32'b000001);
    check("stall_len", cap.size(), 6);

    // Asynchronous reset mid-codeword with a queued symbol
    clear_cap();
    push_sym(4'd15);
    push_sym(4'd3);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, sym_ready}, 32'd1);
    #2;
    rst = 1'b1;
    clear_cap();
    push_sym(4'd2);
    drain(40, "mid_rst_idle");
    check("mid_rst_bits", pack_cap(), 32'b001);
    check("mid_rst_len", cap.size(), 3);

    // Fill while stalled, reject a fifth symbol, then release
    clear_cap();
    out_stall = 1'b1;
    for (int i = 1; i <= FIFO_DEPTH; i++) push_sym(4'(i));
    check("full_ready", {31'd0, sym_ready}, 32'd0);
    push_sym(4'd9);
    check("full_ready2", {31'd0, sym_ready}, 32'd0);
    check("full_accepted", model_q.size(), FIFO_DEPTH);
    check("full_no_output", cap.size(), 0);
    out_stall = 1'b0;
    drain(80, "full_idle");
    exp_bits = model_bits(exp_len);
    check("full_bits", pack_cap(), exp_bits);
    check("full_len", cap.size(), exp_len);

    // Random loopback through a behavioural decoder
    clear_cap();
    n = 0;
    while (n < 200) begin
      sym_valid = ($urandom_range(0, 3) != 0);
      sym_in    = 4'($urandom_range(0, 15));
      out_stall = ($urandom_range(0, 4) == 0);
      if (sym_valid && sym_ready) n++;
      step();
    end
    sym_valid = 1'b0;
    out_stall = 1'b0;
    drain(5000, "rand_idle");
    dec.delete();
    z = 0;
    foreach (cap[i]) begin
      if (cap[i]) begin
        dec.push_back(z);
        z = 0;
      end else begin
        z++;
      end
    end
    check("rand_tail", z, 0);
    check("rand_count", dec.size(), model_q.size());
    for (int i = 0; i < dec.size() && i < model_q.size(); i++)
      check($sformatf("rand_sym%0d", i), dec[i], model_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
